fetch_seq_unit: RTL and testbench

- Parametrised instruction-fetch and PC-sequencing unit for the RV32I single-cycle core.
- Replaces the ad-hoc PC register and the opcode-based "run" gating in the core top.
- Drives the synchronous instruction ROM and absorbs its 1-cycle read latency with no steady-state bubble.
- Accepts branch/JAL/JALR redirects and datapath stalls, halts on unsupported opcodes with a resume handshake, and counts retired instructions.

---
 rtl/fetch_seq_unit.sv | 125 ++++++++++++
 tb/tb_fetch_seq_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq_unit.sv
// fetch_seq_unit: PC sequencing and instruction fetch from a synchronous ROM.
// The ROM is addressed with the *next* PC whenever the current instruction
// advances, so a new instruction is presented every cycle without bubbles.
module fetch_seq_unit #(
    parameter int unsigned     PC_W      = 11,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter int unsigned     CNT_W     = 32
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    output logic [PC_W-3:0]  rom_addr,
    input  logic [31:0]      rom_q,
    input  logic             stall,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             resume,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus4,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        StFill = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_next_pc;
    logic [CNT_W-1:0] r_retired;
    logic            r_illegal;
    logic            w_legal;
    logic            w_adv;
    logic            w_halt_entry;
    logic            w_unused;

    // Redirect targets are always word aligned; the low bits are dropped.
    assign w_unused     = ^redirect_pc[1:0];
    assign w_pc_plus4   = r_pc + PC_W'(4);
    assign w_next_pc    = redirect ? {redirect_pc[PC_W-1:2], 2'b00} : w_pc_plus4;
    assign w_adv        = (r_state == StRun) & ~stall & w_legal;
    assign w_halt_entry = (r_state == StRun) & ~stall & ~w_legal;

    // Opcode decode, gated by RUN so an undefined rom_q cannot leak into control.
    always_comb begin
        w_legal = 1'b0;
        if (r_state == StRun) begin
            case (rom_q[6:0])
                7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011,
                7'b1100011, 7'b1101111, 7'b1100111: w_legal = 1'b1;
                default:                            w_legal = 1'b0;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFill;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StFill:  w_state_next = StRun;
            StRun:   if (w_halt_entry) w_state_next = StHalt;
            StHalt:  if (resume) w_state_next = StFill;
            default: w_state_next = StFill;
        endcase
    end

    // FSM outputs: ROM address selection and status flags.
    always_comb begin
        rom_addr    = r_pc[PC_W-1:2];
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (r_state)
            StRun: begin
                instr_valid = 1'b1;
                if (w_adv) rom_addr = w_next_pc[PC_W-1:2];
            end
            StHalt: begin
                halted   = 1'b1;
                // Pre-address the resume target so FILL sees valid data.
                rom_addr = w_pc_plus4[PC_W-1:2];
            end
            default: ;
        endcase
    end

    // PC, retire counter and one-cycle illegal pulse.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_VEC;
            r_retired <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_halt_entry;
            if (w_adv) begin
                r_pc      <= w_next_pc;
                r_retired <= r_retired + CNT_W'(1);
            end else if ((r_state == StHalt) && resume) begin
                r_pc <= w_pc_plus4;
            end
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign instr    = rom_q;
    assign illegal  = r_illegal;
    assign retired  = r_retired;

endmodule

// File: tb/tb_fetch_seq_unit.sv
// Bench for fetch_seq_unit: a default-sized instance and a small one
// (PC_W=6, CNT_W=4) share stimulus; each is tracked by its own program-level
// model (state name, PC, retire count) with the ROM modelled as mem[pc/4].
module tb_fetch_seq_unit;

    localparam int unsigned BMASK = 32'h0000_07FF;
    localparam int unsigned SMASK = 32'h0000_003F;
    localparam int M_FILL = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [10:0] redirect_pc;
    logic        resume;

    logic [8:0]  b_rom_addr;
    logic [31:0] b_rom_q;
    logic [10:0] b_pc, b_pc_plus4;
    logic [31:0] b_instr;
    logic        b_valid, b_halted, b_illegal;
    logic [31:0] b_retired;

    logic [3:0]  s_rom_addr;
    logic [31:0] s_rom_q;
    logic [5:0]  s_pc, s_pc_plus4;
    logic [31:0] s_instr;
    logic        s_valid, s_halted, s_illegal;
    logic [3:0]  s_retired;

    logic [31:0] mem_b [0:511];
    logic [31:0] mem_s [0:15];

    int          mb_st, ms_st;
    int unsigned mb_pc, ms_pc, mb_ret, ms_ret;
    bit          mb_ill, ms_ill;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) b_rom_q <= mem_b[b_rom_addr];
    always @(posedge clk) s_rom_q <= mem_s[s_rom_addr];

    fetch_seq_unit u_big (
        .CLOCK_50(clk), .rst_n(rst_n), .rom_addr(b_rom_addr), .rom_q(b_rom_q),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .resume(resume),
        .pc(b_pc), .pc_plus4(b_pc_plus4), .instr(b_instr), .instr_valid(b_valid),
        .halted(b_halted), .illegal(b_illegal), .retired(b_retired)
    );

    fetch_seq_unit #(.PC_W(6), .RESET_VEC(6'd0), .CNT_W(4)) u_small (
        .CLOCK_50(clk), .rst_n(rst_n), .rom_addr(s_rom_addr), .rom_q(s_rom_q),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc[5:0]),
        .resume(resume), .pc(s_pc), .pc_plus4(s_pc_plus4), .instr(s_instr),
        .instr_valid(s_valid), .halted(s_halted), .illegal(s_illegal),
        .retired(s_retired)
    );

    function automatic bit is_legal(input logic [31:0] w);
        case (w[6:0])
            7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011,
            7'b1100011, 7'b1101111, 7'b1100111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rand_word(input bit allow_illegal);
        logic [6:0]  ops [0:6];
        logic [31:0] w;
        ops = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011,
                7'b1100011, 7'b1101111, 7'b1100111};
        w = $urandom;
        if (allow_illegal && ($urandom_range(0, 9) == 0))
            w[6:0] = ($urandom_range(0, 1) == 0) ? 7'b0000000 : 7'b1110011;
        else
            w[6:0] = ops[$urandom_range(0, 6)];
        return w;
    endfunction

    // One clock of the program-level model: what the unit should do next.
    task automatic model_step(input logic [31:0] word, input int unsigned pmask,
                              input int unsigned cmask, inout int st,
                              inout int unsigned mpc, inout int unsigned ret,
                              inout bit ill);
        bit entering_halt = 1'b0;
        case (st)
            M_FILL: st = M_RUN;
            M_RUN: begin
                if (!stall) begin
                    if (is_legal(word)) begin
                        if (redirect)
                            mpc = (int'(redirect_pc) & pmask) & 32'hFFFF_FFFC;
                        else
                            mpc = (mpc + 4) & pmask;
                        ret = (ret + 1) & cmask;
                    end else begin
                        st = M_HALT;
                        entering_halt = 1'b1;
                    end
                end
            end
            default: begin
                if (resume) begin
                    mpc = (mpc + 4) & pmask;
                    st  = M_FILL;
                end
            end
        endcase
        ill = entering_halt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(mem_b[mb_pc >> 2], BMASK, 32'hFFFF_FFFF, mb_st, mb_pc, mb_ret, mb_ill);
            model_step(mem_s[ms_pc >> 2], SMASK, 32'h0000_000F, ms_st, ms_pc, ms_ret, ms_ill);
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        mb_st = M_FILL; mb_pc = 0; mb_ret = 0; mb_ill = 1'b0;
        ms_st = M_FILL; ms_pc = 0; ms_ret = 0; ms_ill = 1'b0;
    endtask

    // Hold reset for two cycles, release it away from the rising edge.
    task automatic apply_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; resume = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic load_directed_rom();
        for (int i = 0; i < 512; i++) mem_b[i] = {$urandom_range(0, 32'h1FF_FFFF), 7'b0010011};
        for (int i = 0; i < 4; i++) mem_b[i] = {$urandom_range(0, 32'h1FF_FFFF), 7'b0110011};
        mem_b[4] = 32'h0000_0000;
        for (int i = 0; i < 16; i++) mem_s[i] = {$urandom_range(0, 32'h1FF_FFFF), 7'b0010011};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; resume = 1'b0;
        model_reset();
        #3;
        checks += 6;
        if (b_pc !== 11'd0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", b_pc); end
        if (b_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", b_valid); end
        if (b_halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", b_halted); end
        if (b_illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", b_illegal); end
        if (b_retired !== 32'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", b_retired); end
        if (b_pc_plus4 !== 11'd4) begin failures++; $display("FAIL reset_pc_plus4 got=%0h exp=4", b_pc_plus4); end
    endtask

    task automatic test_fill_run();
        apply_reset();
        #1;
        checks++;
        if (b_valid !== 1'b0) begin failures++; $display("FAIL fill_valid got=%b exp=0", b_valid); end
        tick();
        checks += 2;
        if (b_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", b_valid); end
        if (b_instr !== mem_b[0]) begin failures++; $display("FAIL first_instr got=%h exp=%h", b_instr, mem_b[0]); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks += 2;
            if (b_pc !== 11'(4 * k)) begin
                failures++; $display("FAIL run_pc step=%0d got=%0d exp=%0d", k, b_pc, 4 * k);
            end
            if (b_retired !== 32'(k)) begin
                failures++; $display("FAIL run_retired step=%0d got=%0d exp=%0d", k, b_retired, k);
            end
            if (k < 4) begin
                checks++;
                if (b_instr !== mem_b[k]) begin
                    failures++; $display("FAIL run_instr step=%0d got=%h exp=%h", k, b_instr, mem_b[k]);
                end
            end
        end
    endtask

    task automatic test_stall_illegal();
        logic [31:0] held;
        apply_reset();
        repeat (3) tick();
        stall = 1'b1;
        held = b_instr;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks += 3;
            if (b_pc !== 11'd8) begin failures++; $display("FAIL stall_pc got=%0d exp=8", b_pc); end
            if (b_instr !== held) begin failures++; $display("FAIL stall_instr got=%h exp=%h", b_instr, held); end
            if (b_retired !== 32'd2) begin failures++; $display("FAIL stall_retired got=%0d exp=2", b_retired); end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (b_pc !== 11'd12) begin failures++; $display("FAIL unstall_pc got=%0d exp=12", b_pc); end
        tick();
        tick();
        checks += 5;
        if (b_halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", b_halted); end
        if (b_illegal !== 1'b1) begin failures++; $display("FAIL halt_pulse got=%b exp=1", b_illegal); end
        if (b_valid !== 1'b0) begin failures++; $display("FAIL halt_valid got=%b exp=0", b_valid); end
        if (b_pc !== 11'd16) begin failures++; $display("FAIL halt_pc got=%0d exp=16", b_pc); end
        if (b_retired !== 32'd4) begin failures++; $display("FAIL halt_retired got=%0d exp=4", b_retired); end
        repeat (2) begin
            tick();
            checks += 3;
            if (b_illegal !== 1'b0) begin failures++; $display("FAIL pulse_len got=%b exp=0", b_illegal); end
            if (b_halted !== 1'b1) begin failures++; $display("FAIL halt_hold got=%b exp=1", b_halted); end
            if (b_pc !== 11'd16) begin failures++; $display("FAIL halt_hold_pc got=%0d exp=16", b_pc); end
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        checks += 3;
        if (b_halted !== 1'b0) begin failures++; $display("FAIL resume_halted got=%b exp=0", b_halted); end
        if (b_valid !== 1'b0) begin failures++; $display("FAIL resume_fill got=%b exp=0", b_valid); end
        if (b_pc !== 11'd20) begin failures++; $display("FAIL resume_pc got=%0d exp=20", b_pc); end
        tick();
        checks += 2;
        if (b_valid !== 1'b1) begin failures++; $display("FAIL resume_run got=%b exp=1", b_valid); end
        if (b_instr !== mem_b[5]) begin failures++; $display("FAIL resume_instr got=%h exp=%h", b_instr, mem_b[5]); end
    endtask

    task automatic test_redirect();
        apply_reset();
        repeat (2) tick();
        redirect = 1'b1;
        redirect_pc = 11'h023;
        stall = 1'b1;
        tick();
        checks++;
        if (b_pc !== 11'd4) begin failures++; $display("FAIL redirect_stalled got=%0h exp=4", b_pc); end
        stall = 1'b0;
        #1;
        checks++;
        if (b_rom_addr !== 9'd8) begin failures++; $display("FAIL redirect_addr got=%0d exp=8", b_rom_addr); end
        tick();
        redirect = 1'b0;
        checks += 2;
        if (b_pc !== 11'h020) begin failures++; $display("FAIL redirect_pc got=%0h exp=20", b_pc); end
        if (b_instr !== mem_b[8]) begin failures++; $display("FAIL redirect_instr got=%h exp=%h", b_instr, mem_b[8]); end
    endtask

    task automatic test_wrap();
        apply_reset();
        tick();
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) begin
                checks++;
                if (s_pc_plus4 !== 6'd0) begin failures++; $display("FAIL wrap_plus4 got=%0d exp=0", s_pc_plus4); end
            end
            tick();
            checks += 2;
            if (s_pc !== 6'((4 * i) % 64)) begin
                failures++; $display("FAIL wrap_pc step=%0d got=%0d exp=%0d", i, s_pc, (4 * i) % 64);
            end
            if (s_retired !== 4'(i % 16)) begin
                failures++; $display("FAIL wrap_retired step=%0d got=%0d exp=%0d", i, s_retired, i % 16);
            end
        end
    endtask

    task automatic test_async_reset();
        int budget;
        apply_reset();
        repeat (3) tick();
        stall = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (b_pc !== 11'd0) begin failures++; $display("FAIL areset_stall_pc got=%0d exp=0", b_pc); end
        if (b_retired !== 32'd0) begin failures++; $display("FAIL areset_stall_retired got=%0d exp=0", b_retired); end
        if (b_valid !== 1'b0) begin failures++; $display("FAIL areset_stall_valid got=%b exp=0", b_valid); end
        if (b_halted !== 1'b0) begin failures++; $display("FAIL areset_stall_halted got=%b exp=0", b_halted); end
        apply_reset();
        budget = 20;
        while (!b_halted && budget > 0) begin tick(); budget--; end
        checks++;
        if (budget == 0) begin failures++; $display("FAIL areset_reach_halt got=timeout exp=halted"); end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (b_pc !== 11'd0) begin failures++; $display("FAIL areset_halt_pc got=%0d exp=0", b_pc); end
        if (b_retired !== 32'd0) begin failures++; $display("FAIL areset_halt_retired got=%0d exp=0", b_retired); end
        if (b_halted !== 1'b0) begin failures++; $display("FAIL areset_halt_halted got=%b exp=0", b_halted); end
        if (b_valid !== 1'b0) begin failures++; $display("FAIL areset_halt_valid got=%b exp=0", b_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 512; i++) mem_b[i] = rand_word(1'b1);
        for (int i = 0; i < 16; i++) mem_s[i] = rand_word(1'b1);
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 4) == 0);
            redirect_pc = 11'($urandom);
            resume      = ($urandom_range(0, 2) == 0);
            tick();
            checks += 12;
            if (b_pc !== 11'(mb_pc)) begin failures++; $display("FAIL rnd_b_pc cyc=%0d got=%0h exp=%0h", c, b_pc, mb_pc); end
            if (b_pc_plus4 !== 11'(mb_pc + 4)) begin failures++; $display("FAIL rnd_b_plus4 cyc=%0d got=%0h exp=%0h", c, b_pc_plus4, 11'(mb_pc + 4)); end
            if (b_retired !== mb_ret) begin failures++; $display("FAIL rnd_b_retired cyc=%0d got=%0d exp=%0d", c, b_retired, mb_ret); end
            if (b_valid !== (mb_st == M_RUN)) begin failures++; $display("FAIL rnd_b_valid cyc=%0d got=%b exp=%0d", c, b_valid, mb_st == M_RUN); end
            if (b_halted !== (mb_st == M_HALT)) begin failures++; $display("FAIL rnd_b_halted cyc=%0d got=%b exp=%0d", c, b_halted, mb_st == M_HALT); end
            if (b_illegal !== mb_ill) begin failures++; $display("FAIL rnd_b_illegal cyc=%0d got=%b exp=%b", c, b_illegal, mb_ill); end
            if (s_pc !== 6'(ms_pc)) begin failures++; $display("FAIL rnd_s_pc cyc=%0d got=%0h exp=%0h", c, s_pc, ms_pc); end
            if (s_pc_plus4 !== 6'(ms_pc + 4)) begin failures++; $display("FAIL rnd_s_plus4 cyc=%0d got=%0h exp=%0h", c, s_pc_plus4, 6'(ms_pc + 4)); end
            if (s_retired !== 4'(ms_ret)) begin failures++; $display("FAIL rnd_s_retired cyc=%0d got=%0d exp=%0d", c, s_retired, ms_ret); end
            if (s_valid !== (ms_st == M_RUN)) begin failures++; $display("FAIL rnd_s_valid cyc=%0d got=%b exp=%0d", c, s_valid, ms_st == M_RUN); end
            if (s_halted !== (ms_st == M_HALT)) begin failures++; $display("FAIL rnd_s_halted cyc=%0d got=%b exp=%0d", c, s_halted, ms_st == M_HALT); end
            if (s_illegal !== ms_ill) begin failures++; $display("FAIL rnd_s_illegal cyc=%0d got=%b exp=%b", c, s_illegal, ms_ill); end
            if (mb_st == M_RUN) begin
                checks++;
                if (b_instr !== mem_b[mb_pc >> 2]) begin
                    failures++; $display("FAIL rnd_b_instr cyc=%0d got=%h exp=%h", c, b_instr, mem_b[mb_pc >> 2]);
                end
            end
            if (ms_st == M_RUN) begin
                checks++;
                if (s_instr !== mem_s[ms_pc >> 2]) begin
                    failures++; $display("FAIL rnd_s_instr cyc=%0d got=%h exp=%h", c, s_instr, mem_s[ms_pc >> 2]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        load_directed_rom();
        test_reset();
        test_fill_run();
        test_stall_illegal();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
